// File: rtl/ads868x_scan_seq.sv
// ads868x_scan_seq
// Scan sequencer for an ADS868x ADC behind an external analog mux.
// For each enabled channel it selects the mux input and waits for the mux
// to settle. It then clocks one conversion frame through an SPI master
// byte stream and emits the 16-bit sample on an AXI-Stream output tagged
// with the scan count and channel number.

module ads868x_scan_seq #(
    parameter  int NUM_CH      = 8,
    parameter  int FRAME_BYTES = 4,
    localparam int SEL_W       = $clog2(NUM_CH)
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              enable,
    input  logic              mode,
    input  logic              trig,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [15:0]       settle_cycles,

    output logic [7:0]        spi_tx_tdata,
    output logic              spi_tx_tvalid,
    input  logic              spi_tx_tready,

    input  logic [7:0]        spi_rx_tdata,
    input  logic              spi_rx_tvalid,
    output logic              spi_rx_tready,

    output logic [SEL_W-1:0]  mux_sel,
    output logic              mux_en,

    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,

    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        XFER,
        OUTPUT,
        NEXT
    } state_t;

    // Byte counters only need to reach FRAME_BYTES (at most 4).
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] FRAME_LEN  = CNT_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BYTES - 1);

    state_t            state;
    state_t            state_d;

    logic [SEL_W-1:0]  ch;          // channel currently being converted
    logic [NUM_CH-1:0] mask_r;      // channel mask as sampled at the last decision
    logic [15:0]       settle_r;    // settle delay as sampled at the last decision
    logic [15:0]       settle_cnt;
    logic [CNT_W-1:0]  tx_cnt;
    logic [CNT_W-1:0]  rx_cnt;
    logic [15:0]       sample;
    logic [7:0]        scan_cnt;

    logic              nxt_found;   // a higher set bit exists in the live mask
    logic [SEL_W-1:0]  nxt_ch;
    logic              start_scan;
    logic              restart_scan;

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    // Index of the highest set bit (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] highest_set(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    // Next enabled channel above the current one, from the live mask.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i] && (i > int'(ch))) begin
                nxt_found = 1'b1;
                nxt_ch    = SEL_W'(i);
            end
        end
    end

    assign start_scan   = enable && (ch_mask != '0) && (mode || trig);
    assign restart_scan = mode && enable && (ch_mask != '0);

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from the same clock edge.
            state <= state_d;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d       = state;
        busy          = (state != IDLE);
        spi_tx_tvalid = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;

        case (state)
            IDLE: begin
                if (start_scan) state_d = SELECT;
            end
            SELECT: begin
                state_d = (settle_r == 16'd0) ? XFER : SETTLE;
            end
            SETTLE: begin
                if (settle_cnt <= 16'd1) state_d = XFER;
            end
            XFER: begin
                spi_tx_tvalid = (tx_cnt < FRAME_LEN);
                if (spi_rx_tvalid && (rx_cnt == FRAME_LAST)) state_d = OUTPUT;
            end
            OUTPUT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (ch == highest_set(mask_r));
                if (m_axis_tready) state_d = NEXT;
            end
            NEXT: begin
                if (nxt_found) begin
                    state_d = enable ? SELECT : IDLE;
                end else begin
                    state_d = restart_scan ? SELECT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Channel bookkeeping, mux drive, SPI frame capture and scan counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: every register in this block is reset, including the sample
            // and counters, so a reset mid-frame leaves nothing of the old frame.
            ch         <= '0;
            mask_r     <= '0;
            settle_r   <= '0;
            settle_cnt <= '0;
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            sample     <= '0;
            scan_cnt   <= '0;
            mux_sel    <= '0;
            mux_en     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mask_r   <= ch_mask;
                    settle_r <= settle_cycles;
                    ch       <= lowest_set(ch_mask);
                    mux_en   <= 1'b0;
                end
                SELECT: begin
                    mux_sel    <= ch;
                    mux_en     <= 1'b1;
                    settle_cnt <= settle_r;
                    tx_cnt     <= '0;
                    rx_cnt     <= '0;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 16'd1;
                end
                XFER: begin
                    if (spi_tx_tvalid && spi_tx_tready) tx_cnt <= tx_cnt + 1'b1;
                    if (spi_rx_tvalid) begin
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt == '0) sample[15:8] <= spi_rx_tdata;
                        if (rx_cnt == CNT_W'(1)) sample[7:0] <= spi_rx_tdata;
                    end
                end
                NEXT: begin
                    // Mask and settle delay changes take effect here.
                    mask_r   <= ch_mask;
                    settle_r <= settle_cycles;
                    if (nxt_found) begin
                        // Enable low abandons the rest of the scan; count unchanged.
                        if (enable) ch <= nxt_ch;
                        else        mux_en <= 1'b0;
                    end else begin
                        scan_cnt <= scan_cnt + 8'd1;
                        if (restart_scan) ch <= lowest_set(ch_mask);
                        else              mux_en <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun: a trigger while busy; cleared only while disabled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overrun <= 1'b0;
        end else if (trig && busy) begin
            overrun <= 1'b1;
        end else if (!enable) begin
            overrun <= 1'b0;
        end
    end

    assign spi_tx_tdata  = 8'h00;
    assign spi_rx_tready = 1'b1;
    assign m_axis_tdata  = {scan_cnt, 8'(ch), sample};

endmodule

// File: tb/tb_ads868x_scan_seq.sv
// tb_ads868x_scan_seq
// Directed bench for ads868x_scan_seq with default parameters (8 channels,
// 4-byte frames). A small SPI responder answers each accepted tx byte with
// the next byte of rx_pat, and a monitor queues every handshaked sample.

module tb_ads868x_scan_seq;

    logic        aclk;
    logic        aresetn;
    logic        enable;
    logic        mode;
    logic        trig;
    logic [7:0]  ch_mask;
    logic [15:0] settle_cycles;
    logic [7:0]  spi_tx_tdata;
    logic        spi_tx_tvalid;
    logic        spi_tx_tready;
    logic [7:0]  spi_rx_tdata;
    logic        spi_rx_tvalid;
    logic        spi_rx_tready;
    logic [2:0]  mux_sel;
    logic        mux_en;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        overrun;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          tx_bytes = 0;
    int          byte_idx = 0;
    logic [7:0]  rx_pat [4];
    logic [32:0] sample_q [$];

    ads868x_scan_seq #(.NUM_CH(8), .FRAME_BYTES(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .mode          (mode),
        .trig          (trig),
        .ch_mask       (ch_mask),
        .settle_cycles (settle_cycles),
        .spi_tx_tdata  (spi_tx_tdata),
        .spi_tx_tvalid (spi_tx_tvalid),
        .spi_tx_tready (spi_tx_tready),
        .spi_rx_tdata  (spi_rx_tdata),
        .spi_rx_tvalid (spi_rx_tvalid),
        .spi_rx_tready (spi_rx_tready),
        .mux_sel       (mux_sel),
        .mux_en        (mux_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .overrun       (overrun)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // SPI responder: each byte the master accepts returns one rx byte.
    always @(negedge aclk) begin
        if (!aresetn) begin
            spi_rx_tvalid = 1'b0;
            spi_rx_tdata  = 8'h00;
            byte_idx      = 0;
        end else if (spi_tx_tvalid && spi_tx_tready) begin
            spi_rx_tvalid = 1'b1;
            spi_rx_tdata  = rx_pat[byte_idx];
            byte_idx      = (byte_idx + 1) % 4;
        end else begin
            spi_rx_tvalid = 1'b0;
        end
    end

    // Count accepted tx bytes (all must be 0x00) and record delivered samples.
    always @(posedge aclk) begin
        if (aresetn && spi_tx_tvalid && spi_tx_tready) begin
            tx_bytes = tx_bytes + 1;
            if (spi_tx_tdata !== 8'h00) chk("tx_byte_zero", 64'(spi_tx_tdata), 64'h0);
        end
        if (aresetn && m_axis_tvalid && m_axis_tready)
            sample_q.push_back({m_axis_tlast, m_axis_tdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(negedge aclk);
        trig = 1'b0;
    endtask

    // Counts cycles with the mux enabled but no SPI or sample activity,
    // until the first tx byte is offered.
    task automatic wait_for_tx(input string tag, output int gap);
        int n;
        gap = 0;
        n   = 0;
        while (!spi_tx_tvalid && n < 300) begin
            @(negedge aclk);
            if (mux_en && !spi_tx_tvalid && !m_axis_tvalid) gap++;
            n++;
        end
        chk(tag, 64'(spi_tx_tvalid), 64'h1);
    endtask

    task automatic wait_for_out(input string tag);
        int n;
        n = 0;
        while (!m_axis_tvalid && n < 300) begin
            @(negedge aclk);
            n++;
        end
        chk(tag, 64'(m_axis_tvalid), 64'h1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge aclk);
        while (busy && n < budget) begin
            @(negedge aclk);
            n++;
        end
        chk(tag, 64'(busy), 64'h0);
    endtask

    task automatic pop_chk(input string tag, input logic [32:0] exp);
        logic [32:0] got;
        got = 'x;
        if (sample_q.size() > 0) got = sample_q.pop_front();
        chk(tag, 64'(got), 64'(exp));
    endtask

    initial begin
        int gap;
        int stable_err;
        int n;

        aresetn       = 1'b0;
        enable        = 1'b0;
        mode          = 1'b0;
        trig          = 1'b0;
        ch_mask       = 8'h00;
        settle_cycles = 16'd0;
        spi_tx_tready = 1'b1;
        m_axis_tready = 1'b1;
        rx_pat[0] = 8'hAB; rx_pat[1] = 8'hCD; rx_pat[2] = 8'h11; rx_pat[3] = 8'h22;

        // Reset state.
        repeat (3) @(negedge aclk);
        chk("rst_outputs", 64'({busy, mux_en, mux_sel, spi_tx_tvalid, m_axis_tvalid, m_axis_tlast, overrun}), 64'h0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'h0);
        chk("rst_rx_tready", 64'(spi_rx_tready), 64'h1);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Mode 0, mask 0x05, settle 3: channel 0 then channel 2.
        enable        = 1'b1;
        ch_mask       = 8'h05;
        settle_cycles = 16'd3;
        pulse_trig();
        wait_for_tx("ch0_reach_xfer", gap);
        chk("ch0_settle_cycles", 64'(gap), 64'd3);
        chk("ch0_mux_sel", 64'(mux_sel), 64'd0);
        wait_for_out("ch0_reach_output");
        wait_for_tx("ch2_reach_xfer", gap);
        chk("ch2_next_select_settle", 64'(gap), 64'd5);  // NEXT + SELECT + 3 settle
        chk("ch2_mux_sel", 64'(mux_sel), 64'd2);
        wait_idle("scan1_idle", 200);
        chk("scan1_tx_bytes", 64'(tx_bytes), 64'd8);
        chk("scan1_n_samples", 64'(sample_q.size()), 64'd2);
        pop_chk("scan1_sample_ch0", {1'b0, 32'h0000_ABCD});
        pop_chk("scan1_sample_ch2", {1'b1, 32'h0002_ABCD});
        chk("scan1_mux_en_off", 64'(mux_en), 64'h0);
        chk("scan1_no_overrun", 64'(overrun), 64'h0);

        // Backpressure on channel 1; a trigger during the stall is an overrun.
        rx_pat[0] = 8'h12; rx_pat[1] = 8'h34; rx_pat[2] = 8'h56; rx_pat[3] = 8'h78;
        ch_mask       = 8'h02;
        settle_cycles = 16'd0;
        m_axis_tready = 1'b0;
        pulse_trig();
        wait_for_out("bp_reach_output");
        chk("bp_tdata", 64'(m_axis_tdata), 64'h0101_1234);
        chk("bp_tlast", 64'(m_axis_tlast), 64'h1);
        stable_err = 0;
        for (int i = 0; i < 50; i++) begin
            trig = (i == 10);
            @(negedge aclk);
            if (m_axis_tdata !== 32'h0101_1234 || !m_axis_tvalid) stable_err++;
        end
        trig = 1'b0;
        chk("bp_tdata_stable", 64'(stable_err), 64'd0);
        chk("bp_no_spi_bytes", 64'(tx_bytes), 64'd12);
        chk("bp_overrun_set", 64'(overrun), 64'h1);
        m_axis_tready = 1'b1;
        wait_idle("bp_idle", 200);
        chk("bp_n_samples", 64'(sample_q.size()), 64'd1);
        pop_chk("bp_sample", {1'b1, 32'h0101_1234});
        repeat (3) @(negedge aclk);
        chk("overrun_held", 64'(overrun), 64'h1);
        enable = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        chk("overrun_cleared", 64'(overrun), 64'h0);

        // Empty mask: a trigger does nothing.
        enable  = 1'b1;
        ch_mask = 8'h00;
        pulse_trig();
        repeat (5) @(negedge aclk);
        chk("empty_mask_busy", 64'(busy), 64'h0);
        chk("empty_mask_mux_en", 64'(mux_en), 64'h0);
        chk("empty_mask_tx_bytes", 64'(tx_bytes), 64'd12);

        // Mask 0x07: drop enable in the settle of channel 1.
        rx_pat[0] = 8'hAB; rx_pat[1] = 8'hCD; rx_pat[2] = 8'h11; rx_pat[3] = 8'h22;
        ch_mask       = 8'h07;
        settle_cycles = 16'd4;
        pulse_trig();
        n = 0;
        while (!(mux_en && mux_sel == 3'd1) && n < 300) begin
            @(negedge aclk);
            n++;
        end
        chk("abort_reach_ch1", 64'(mux_sel), 64'd1);
        chk("abort_ch1_settling", 64'(spi_tx_tvalid), 64'h0);
        enable = 1'b0;
        wait_idle("abort_idle", 200);
        chk("abort_tx_bytes", 64'(tx_bytes), 64'd20);
        chk("abort_n_samples", 64'(sample_q.size()), 64'd2);
        pop_chk("abort_sample_ch0", {1'b0, 32'h0200_ABCD});
        pop_chk("abort_sample_ch1", {1'b0, 32'h0201_ABCD});
        chk("abort_mux_en_off", 64'(mux_en), 64'h0);

        // Next scan shows scan count still 2 after the abandoned scan.
        enable        = 1'b1;
        ch_mask       = 8'h01;
        settle_cycles = 16'd0;
        pulse_trig();
        wait_idle("cnt_idle", 200);
        pop_chk("cnt_unchanged_sample", {1'b1, 32'h0200_ABCD});

        // Reset in the middle of a frame: outputs return to reset values at once.
        ch_mask       = 8'h06;
        settle_cycles = 16'd2;
        pulse_trig();
        wait_for_tx("rst_reach_xfer", gap);
        chk("rst_settle_cycles", 64'(gap), 64'd2);
        @(negedge aclk);
        chk("rst_first_ch", 64'(mux_sel), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("rst_async_outputs", 64'({busy, mux_en, mux_sel, spi_tx_tvalid, m_axis_tvalid, m_axis_tlast, overrun}), 64'h0);
        chk("rst_async_tdata", 64'(m_axis_tdata), 64'h0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        sample_q.delete();
        @(negedge aclk);
        chk("rst_stays_idle", 64'(busy), 64'h0);

        // Free-running single channel: scan count runs 0..255 then wraps to 0.
        ch_mask       = 8'h80;
        settle_cycles = 16'd0;
        mode          = 1'b1;
        n = 0;
        while (sample_q.size() < 257 && n < 6000) begin
            @(negedge aclk);
            n++;
        end
        mode = 1'b0;
        chk("free_run_n_samples", 64'(sample_q.size() >= 257), 64'h1);
        for (int i = 0; i < 257; i++) begin
            logic [7:0] sc;
            sc = 8'(i);
            pop_chk($sformatf("free_run_%0d", i), {1'b1, sc, 8'd7, 16'hABCD});
        end
        wait_idle("free_run_stop", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ads868x_scan_seq.md
ADS868X_SCAN_SEQ -- requirements
Module: ads868x_scan_seq

Interface
REQ-001 Parameter NUM_CH, default 8, number of mux channels scanned (legal 2..32).
REQ-002 Parameter FRAME_BYTES, default 4, SPI bytes per conversion frame (legal 2..4).
REQ-003 Derived constant SEL_W = clog2(NUM_CH), not overridable.
REQ-004 aclk  in  1  sole clock; all logic rising-edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  level; scanning allowed while high.
REQ-007 mode  in  1  0 = one scan per trig pulse, 1 = free-running scans.
REQ-008 trig  in  1  synchronous start pulse, e.g. pps (mode 0 only).
REQ-009 ch_mask  in  NUM_CH  bit i set = channel i included in scan.
REQ-010 settle_cycles  in  16  mux settle delay in aclk cycles.
REQ-011 spi_tx_tdata/tvalid/tready  out/out/in  8/1/1  byte stream to SPI master.
REQ-012 spi_rx_tdata/tvalid/tready  in/in/out  8/1/1  byte stream from SPI master.
REQ-013 mux_sel  out  SEL_W  external mux channel select.
REQ-014 mux_en  out  1  external mux enable.
REQ-015 m_axis_tdata  out  32  {scan_cnt[7:0], ch[7:0], sample[15:0]}.
REQ-016 m_axis_tvalid/tready/tlast  out/in/out  1/1/1  sample stream; tlast on last channel of scan.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 overrun  out  1  sticky: trig arrived while busy.

Function
REQ-019 States SHALL be IDLE, SELECT, SETTLE, XFER, OUTPUT, NEXT.
REQ-020 IDLE -> SELECT when enable=1 and ch_mask!=0 and (mode=1 or trig=1); current channel = lowest set bit of ch_mask.
REQ-021 ch_mask=0 SHALL keep IDLE; no SPI traffic, mux_en=0.
REQ-022 SELECT (1 cycle): mux_sel <= channel, mux_en <= 1, settle counter <= settle_cycles; -> SETTLE, or -> XFER if settle_cycles=0.
REQ-023 SETTLE: decrement per cycle; -> XFER on the cycle counter reaches 0 (exactly settle_cycles cycles in SETTLE).
REQ-024 XFER: spi_tx_tdata=0x00, tvalid high until FRAME_BYTES bytes accepted (tvalid&tready), then low.
REQ-025 XFER: sample[15:8] = rx byte 0, sample[7:0] = rx byte 1, remaining rx bytes discarded; -> OUTPUT when FRAME_BYTES rx bytes received.
REQ-026 spi_rx_tready SHALL be constantly 1; rx bytes outside XFER discarded.
REQ-027 OUTPUT: m_axis_tvalid=1, data stable until tready; backpressure stalls scan, no sample dropped; -> NEXT on handshake.
REQ-028 tlast=1 iff current channel is highest set bit of ch_mask.
REQ-029 NEXT: if not last, channel = next higher set bit -> SELECT; if last, scan_cnt += 1 (8-bit wrap 255->0).
REQ-030 After last: mode=1 and enable=1 -> SELECT at lowest set bit; else -> IDLE, mux_en <= 0.
REQ-031 ch_mask and settle_cycles SHALL be sampled in IDLE and at each NEXT; changes mid-frame take effect at next channel decision.
REQ-032 enable low mid-scan: current frame and its OUTPUT complete (SPI never aborted), then -> IDLE; remaining channels skipped, scan_cnt unchanged.
REQ-033 trig while busy or mode=1: ignored; sets overrun if busy; overrun cleared only while enable=0.
REQ-034 trig and scan completion in same cycle: trig counts as overrun, no new scan started in mode 0.

Reset
REQ-035 aresetn=0 SHALL force IDLE, busy=0, overrun=0, mux_en=0, mux_sel=0, spi_tx_tvalid=0, m_axis_tvalid=0, tlast=0, scan_cnt=0, counters 0, asynchronously; release synchronous to aclk.
REQ-036 Reset mid-XFER SHALL abandon the frame; first post-reset scan starts at lowest set bit.

Verification
REQ-037 mode=0, ch_mask=0x05, settle=3, trig pulse -> ch 0 then ch 2 frames, 3 SETTLE cycles each, 4 tx bytes 0x00 each, tdata 0x0000xxxx then 0x0002xxxx with tlast on 2nd, then IDLE.
REQ-038 rx bytes 0xAB,0xCD,0x11,0x22 -> sample=0xABCD.
REQ-039 mode=1, ch_mask=0x80, 256 scans -> scan_cnt field 0..255 then 0; tlast every sample.
REQ-040 m_axis_tready low 50 cycles in OUTPUT -> tdata stable, no SPI bytes issued, resumes after handshake.
REQ-041 trig during scan -> overrun=1, held until enable=0; ch_mask=0 plus trig -> no tx bytes, busy=0.
REQ-042 enable dropped in SETTLE of ch 1 (mask 0x07) -> ch 1 frame and sample complete, ch 2 skipped, IDLE, mux_en=0; aresetn pulse mid-XFER -> all outputs at reset values immediately.
